// File: rtl/ring_shift_pkg.sv
// ring_shift_pkg: mode encodings and the shared next-value function for ring_shift_reg.
// Contents: MODE_* encodings, is_left/is_right direction helpers, shift_next().
package ring_shift_pkg;

    localparam int MAX_W = 64;

    localparam logic [2:0] MODE_HOLD   = 3'd0;
    localparam logic [2:0] MODE_ROT_L  = 3'd1;
    localparam logic [2:0] MODE_ROT_R  = 3'd2;
    localparam logic [2:0] MODE_SHL    = 3'd3;
    localparam logic [2:0] MODE_SHR    = 3'd4;
    localparam logic [2:0] MODE_JOHN_L = 3'd5;
    localparam logic [2:0] MODE_JOHN_R = 3'd6;

    function automatic logic is_left(input logic [2:0] mode);
        return mode == MODE_ROT_L || mode == MODE_SHL || mode == MODE_JOHN_L;
    endfunction

    function automatic logic is_right(input logic [2:0] mode);
        return mode == MODE_ROT_R || mode == MODE_SHR || mode == MODE_JOHN_R;
    endfunction

    // value is zero-extended to MAX_W; w is the live register width.
    // The mask clears the bit shifted past the MSB on left moves
    // (for w == MAX_W the shift wraps to 0 and the mask becomes all ones).
    function automatic logic [MAX_W-1:0] shift_next(
        input logic [MAX_W-1:0] value,
        input logic [2:0]       mode,
        input logic             sin,
        input int unsigned      w
    );
        logic [MAX_W-1:0] one, mask, top, shl, shr;
        logic msb, lsb;
        one  = {{(MAX_W-1){1'b0}}, 1'b1};
        mask = (one << w) - one;
        top  = one << (w - 1);
        msb  = |(value & top);
        lsb  = value[0];
        shl  = (value << 1) & mask;
        shr  = value >> 1;
        case (mode)
            MODE_ROT_L:  shift_next = shl | {{(MAX_W-1){1'b0}}, msb};
            MODE_ROT_R:  shift_next = shr | (lsb ? top : '0);
            MODE_SHL:    shift_next = shl | {{(MAX_W-1){1'b0}}, sin};
            MODE_SHR:    shift_next = shr | (sin ? top : '0);
            MODE_JOHN_L: shift_next = shl | {{(MAX_W-1){1'b0}}, ~msb};
            MODE_JOHN_R: shift_next = shr | (lsb ? '0 : top);
            default:     shift_next = value;
        endcase
    endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer: programmable prescaler producing a step strobe every period+1 enabled cycles.
// Ports: CLK clock; _RST sync active-low reset; clr restart count (load);
//        en count enable; period interval minus one; tick step due on this edge.
module step_timer #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             _RST,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so lowering period below cnt fires on the next enabled edge.
    assign tick = en && !clr && (cnt >= period);

    always_ff @(posedge CLK) begin
        if (!_RST)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/ring_shift_reg.sv
// ring_shift_reg: parametrised universal shift/ring register with step prescaler and wrap flag.
// Ports: CLK clock; _RST sync active-low reset; pre load request; IN load value;
//        mode shift mode; sin serial input; en prescaler enable; period step interval-1;
//        LED register contents; sout last bit shifted out; step advance pulse;
//        wrap pulse when the post-step value equals the loaded reference.
module ring_shift_reg
    import ring_shift_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             _RST,
    input  logic             pre,
    input  logic [WIDTH-1:0] IN,
    input  logic [2:0]       mode,
    input  logic             sin,
    input  logic             en,
    input  logic [DIV_W-1:0] period,
    output logic [WIDTH-1:0] LED,
    output logic             sout,
    output logic             step,
    output logic             wrap
);

    logic             tick;
    logic [WIDTH-1:0] ref_val;
    logic [WIDTH-1:0] nxt;
    logic             sout_nxt;

    step_timer #(.DIV_W(DIV_W)) u_timer (
        .CLK(CLK),
        ._RST(_RST),
        .clr(pre),
        .en(en),
        .period(period),
        .tick(tick)
    );

    assign nxt      = WIDTH'(shift_next(MAX_W'(LED), mode, sin, WIDTH));
    assign sout_nxt = is_left(mode) ? LED[WIDTH-1] : is_right(mode) ? LED[0] : sout;

    always_ff @(posedge CLK) begin
        if (!_RST) begin
            LED     <= '0;
            ref_val <= '0;
            sout    <= 1'b0;
            step    <= 1'b0;
            wrap    <= 1'b0;
        end else if (pre) begin
            LED     <= IN;
            ref_val <= IN;
            step    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            step <= tick;
            wrap <= tick && (nxt == ref_val);
            if (tick) begin
                LED  <= nxt;
                sout <= sout_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ring_shift_reg.sv
// tb_ring_shift_reg: directed and randomized checks of ring_shift_reg against an arithmetic model.
module tb_ring_shift_reg;

    localparam int W = 4;
    localparam int D = 8;
    localparam int M = 1 << W;
    localparam int H = M / 2;

    logic         CLK = 1'b0;
    logic         _RST = 1'b0;
    logic         pre = 1'b0;
    logic [W-1:0] IN = '0;
    logic [2:0]   mode = '0;
    logic         sin = 1'b0;
    logic         en = 1'b0;
    logic [D-1:0] period = '0;
    logic [W-1:0] LED;
    logic         sout, step, wrap;

    int checks = 0;
    int errors = 0;
    int m_led = 0, m_ref = 0, m_cnt = 0, m_sout = 0, m_step = 0, m_wrap = 0;

    always #5 CLK = ~CLK;

    ring_shift_reg #(.WIDTH(W), .DIV_W(D)) dut (
        .CLK(CLK), ._RST(_RST), .pre(pre), .IN(IN), .mode(mode), .sin(sin),
        .en(en), .period(period), .LED(LED), .sout(sout), .step(step), .wrap(wrap)
    );

    function automatic int m_next(int v, int md, int s);
        case (md)
            1: return (v * 2) % M + v / H;
            2: return v / 2 + (v % 2) * H;
            3: return (v * 2) % M + s;
            4: return v / 2 + s * H;
            5: return (v * 2) % M + (1 - v / H);
            6: return v / 2 + (1 - v % 2) * H;
            default: return v;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        int md, fire;
        @(posedge CLK);
        md = int'(mode);
        if (!_RST) begin
            m_led = 0; m_ref = 0; m_cnt = 0; m_sout = 0; m_step = 0; m_wrap = 0;
        end else if (pre) begin
            m_led = int'(IN); m_ref = int'(IN); m_cnt = 0; m_step = 0; m_wrap = 0;
        end else begin
            fire = (en && m_cnt >= int'(period)) ? 1 : 0;
            if (en) m_cnt = fire ? 0 : m_cnt + 1;
            m_step = fire;
            m_wrap = 0;
            if (fire) begin
                if (md == 1 || md == 3 || md == 5) m_sout = m_led / H;
                if (md == 2 || md == 4 || md == 6) m_sout = m_led % 2;
                m_led = m_next(m_led, md, int'(sin));
                m_wrap = (m_led == m_ref) ? 1 : 0;
            end
        end
        #1;
        chk("model_led", 32'(LED), 32'(m_led));
        chk("model_step", 32'(step), 32'(m_step));
        chk("model_wrap", 32'(wrap), 32'(m_wrap));
        chk("model_sout", 32'(sout), 32'(m_sout));
    endtask

    task automatic load(logic [W-1:0] v);
        pre = 1'b1;
        IN = v;
        cyc();
        pre = 1'b0;
    endtask

    initial begin
        int rot_led[4];
        int john_led[8];
        int sins[4];
        rot_led  = '{2, 4, 8, 1};
        john_led = '{8, 12, 14, 15, 7, 3, 1, 0};
        sins     = '{1, 0, 1, 1};

        // reset held with pre asserted
        pre = 1'b1; IN = 4'hF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_led", 32'(LED), 0);
            chk("rst_pulses", {29'd0, step, wrap, sout}, 0);
        end

        // load then rotate left
        _RST = 1'b1; mode = 3'd1; en = 1'b1; period = '0;
        load(4'b0001);
        chk("load_led", 32'(LED), 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rotl_led", 32'(LED), 32'(rot_led[i]));
            chk("rotl_wrap", 32'(wrap), (i == 3) ? 1 : 0);
            chk("rotl_sout", 32'(sout), (i == 3) ? 1 : 0);
        end

        // Johnson right from zero
        mode = 3'd6;
        load(4'b0000);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("johnr_led", 32'(LED), 32'(john_led[i]));
            chk("johnr_wrap", 32'(wrap), (i == 7) ? 1 : 0);
        end

        // prescaler period=2
        mode = 3'd1; period = 8'd2;
        load(4'b0001);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk("div_step", 32'(step), (i % 3 == 0) ? 1 : 0);
        end
        cyc();
        chk("div_pre_pause", 32'(step), 0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("div_paused", 32'(step), 0);
        end
        en = 1'b1;
        cyc();
        chk("div_resume1", 32'(step), 0);
        cyc();
        chk("div_resume2", 32'(step), 1);
        cyc();
        cyc();
        chk("div_cnt2", 32'(step), 0);
        period = 8'd0;
        cyc();
        chk("div_lowered", 32'(step), 1);

        // serial shift left
        mode = 3'd3;
        load(4'b0000);
        for (int i = 0; i < 4; i++) begin
            sin = 1'(sins[i]);
            cyc();
            chk("shl_sout", 32'(sout), 0);
            chk("shl_step", 32'(step), 1);
        end
        chk("shl_led", 32'(LED), 32'hB);
        sin = 1'b0;

        // load colliding with a due step
        mode = 3'd1; period = 8'd2;
        load(4'b0001);
        cyc();
        cyc();
        load(4'b0101);
        chk("coll_led", 32'(LED), 5);
        chk("coll_step", 32'(step), 0);
        cyc();
        cyc();
        chk("coll_wait", 32'(step), 0);
        cyc();
        chk("coll_step3", 32'(step), 1);
        chk("coll_led3", 32'(LED), 32'hA);

        // reset beats load
        _RST = 1'b0; pre = 1'b1; IN = 4'hF;
        cyc();
        chk("rst_vs_pre", 32'(LED), 0);
        _RST = 1'b1; pre = 1'b0;

        // randomized run against the model
        for (int i = 0; i < 600; i++) begin
            _RST = ($urandom_range(0, 59) != 0);
            pre  = ($urandom_range(0, 24) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = 3'($urandom_range(0, 7));
            sin  = 1'($urandom_range(0, 1));
            IN   = W'($urandom);
            if ($urandom_range(0, 15) == 0) period = D'($urandom_range(0, 3));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
